// File: rtl/mem_stage.sv
// Memory stage of the G1 pipeline: EXE/MEM register, data-memory access FSM
// with req/ack handshake and timeout abort, and the MEM/WB register.
module mem_stage #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int REG_ADDR_W  = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     st_value_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    output logic                  mem_stall,
    output logic [REG_ADDR_W-1:0] dest_MEM,
    output logic                  WB_EN_MEM,
    output logic [DATA_W-1:0]     mem_result_fwd,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic [DATA_W-1:0]     writeVal,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  writeEn,
    output logic                  mem_err
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

    state_t                  state;
    logic [7:0]              timeout_cnt;

    logic [DATA_W-1:0]       em_alu;
    logic [DATA_W-1:0]       em_st;
    logic [REG_ADDR_W-1:0]   em_dest;
    logic                    em_wb;
    logic                    em_load;
    logic                    em_store;

    logic                    in_access;
    logic                    last_cycle;
    logic                    mem_op_in;

    assign in_access  = (state == ACCESS);
    assign last_cycle = in_access && (timeout_cnt == LAST_CNT);
    assign mem_op_in  = mem_r_en_in | mem_w_en_in;

    // The final timeout cycle releases the stall so the pipeline moves on.
    assign mem_stall  = in_access & ~dmem_ack & ~last_cycle;

    assign dmem_req       = in_access;
    assign dmem_we        = in_access & em_store;
    assign dmem_addr      = em_alu[ADDR_W-1:0];
    assign dmem_wdata     = em_st;
    assign dest_MEM       = em_dest;
    assign WB_EN_MEM      = em_wb;
    assign mem_result_fwd = em_alu;

    // A store wins over a load and never writes back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            em_alu   <= '0;
            em_st    <= '0;
            em_dest  <= '0;
            em_wb    <= 1'b0;
            em_load  <= 1'b0;
            em_store <= 1'b0;
        end else if (!mem_stall) begin
            em_alu   <= alu_result_in;
            em_st    <= st_value_in;
            em_dest  <= dest_in;
            em_wb    <= wb_en_in & ~mem_w_en_in;
            em_load  <= mem_r_en_in & ~mem_w_en_in;
            em_store <= mem_w_en_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            timeout_cnt <= '0;
            mem_err     <= 1'b0;
        end else if (mem_stall) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end else begin
            state       <= mem_op_in ? ACCESS : IDLE;
            timeout_cnt <= '0;
            if (last_cycle && !dmem_ack) begin
                mem_err <= 1'b1;
            end
        end
    end

    // An aborted load reaches here without ack and must not write back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writeVal <= '0;
            dest     <= '0;
            writeEn  <= 1'b0;
        end else if (mem_stall) begin
            writeEn <= 1'b0;
        end else if (em_store) begin
            writeEn <= 1'b0;
        end else if (em_load) begin
            writeVal <= dmem_rdata;
            dest     <= em_dest;
            writeEn  <= em_wb & dmem_ack;
        end else begin
            writeVal <= em_alu;
            dest     <= em_dest;
            writeEn  <= em_wb;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: instruction-level model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_mem_stage;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int REG_ADDR_W  = 4;
    localparam int TIMEOUT_CYC = 15;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [DATA_W-1:0]     alu_result_in = '0;
    logic [DATA_W-1:0]     st_value_in = '0;
    logic [REG_ADDR_W-1:0] dest_in = '0;
    logic                  wb_en_in = 1'b0;
    logic                  mem_r_en_in = 1'b0;
    logic                  mem_w_en_in = 1'b0;
    logic [DATA_W-1:0]     dmem_rdata = '0;
    logic                  dmem_ack = 1'b0;
    logic                  mem_stall;
    logic [REG_ADDR_W-1:0] dest_MEM;
    logic                  WB_EN_MEM;
    logic [DATA_W-1:0]     mem_result_fwd;
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_W-1:0]     dmem_addr;
    logic [DATA_W-1:0]     dmem_wdata;
    logic [DATA_W-1:0]     writeVal;
    logic [REG_ADDR_W-1:0] dest;
    logic                  writeEn;
    logic                  mem_err;

    int total = 0;
    int bad   = 0;

    mem_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .REG_ADDR_W(REG_ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_result_in(alu_result_in), .st_value_in(st_value_in),
        .dest_in(dest_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .mem_stall(mem_stall), .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM),
        .mem_result_fwd(mem_result_fwd), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .writeVal(writeVal), .dest(dest), .writeEn(writeEn), .mem_err(mem_err)
    );

    initial forever #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Model: the instruction occupying the MEM slot and how long it has waited.
    logic [DATA_W-1:0]     s_alu = '0;
    logic [DATA_W-1:0]     s_st = '0;
    logic [REG_ADDR_W-1:0] s_dest = '0;
    logic                  s_wb = 1'b0;
    logic                  s_load = 1'b0;
    logic                  s_store = 1'b0;
    logic                  s_busy = 1'b0;
    int                    s_waited = 0;
    logic [DATA_W-1:0]     m_wv = '0;
    logic [REG_ADDR_W-1:0] m_dest = '0;
    logic                  m_we = 1'b0;
    logic                  m_err = 1'b0;
    logic                  exp_stall;

    always_comb exp_stall = s_busy && !dmem_ack && (s_waited != TIMEOUT_CYC - 1);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_alu = '0; s_st = '0; s_dest = '0;
            s_wb = 0; s_load = 0; s_store = 0; s_busy = 0; s_waited = 0;
            m_wv = '0; m_dest = '0; m_we = 0; m_err = 0;
        end else if (exp_stall) begin
            m_we = 0;
            s_waited++;
        end else begin
            if (!s_busy) begin
                m_wv = s_alu; m_dest = s_dest; m_we = s_wb;
            end else if (!dmem_ack) begin
                m_we = 0; m_err = 1;
            end else if (s_load) begin
                m_wv = dmem_rdata; m_dest = s_dest; m_we = s_wb;
            end else begin
                m_we = 0;
            end
            s_alu    = alu_result_in;
            s_st     = st_value_in;
            s_dest   = dest_in;
            s_store  = mem_w_en_in;
            s_load   = mem_r_en_in && !mem_w_en_in;
            s_wb     = wb_en_in && !mem_w_en_in;
            s_busy   = mem_r_en_in || mem_w_en_in;
            s_waited = 0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst === 1'b1) begin
            check_output("mem_stall", mem_stall, exp_stall);
            check_output("dmem_req", dmem_req, s_busy);
            check_output("dmem_we", dmem_we, s_busy && s_store);
            if (s_busy) check_output("dmem_addr", dmem_addr, s_alu);
            if (s_busy && s_store) check_output("dmem_wdata", dmem_wdata, s_st);
            check_output("dest_MEM", dest_MEM, s_dest);
            check_output("WB_EN_MEM", WB_EN_MEM, s_wb);
            check_output("mem_result_fwd", mem_result_fwd, s_alu);
            check_output("writeEn", writeEn, m_we);
            check_output("mem_err", mem_err, m_err);
            if (m_we) begin
                check_output("writeVal", writeVal, m_wv);
                check_output("dest", dest, m_dest);
            end
        end
    end

    task automatic apply_stimulus(input logic [15:0] alu, input logic [15:0] st,
                                  input logic [3:0] d, input logic wb, input logic r,
                                  input logic w, input logic ack, input logic [15:0] rdata);
        @(negedge clk);
        alu_result_in = alu; st_value_in = st; dest_in = d; wb_en_in = wb;
        mem_r_en_in = r; mem_w_en_in = w; dmem_ack = ack; dmem_rdata = rdata;
    endtask

    int req_cycles;

    initial begin
        #2;
        check_output("rst_stall", mem_stall, 0);
        check_output("rst_req", dmem_req, 0);
        check_output("rst_writeEn", writeEn, 0);
        check_output("rst_writeVal", writeVal, 0);
        check_output("rst_err", mem_err, 0);
        check_output("rst_wbenmem", WB_EN_MEM, 0);
        @(negedge clk);
        rst = 1'b1;

        // ALU passthrough
        apply_stimulus(16'h1234, 0, 3, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); #3;
        check_output("alu_wbenmem", WB_EN_MEM, 1);
        check_output("alu_destmem", dest_MEM, 3);
        check_output("alu_stall", mem_stall, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); #3;
        check_output("alu_writeVal", writeVal, 16'h1234);
        check_output("alu_dest", dest, 3);
        check_output("alu_writeEn", writeEn, 1);

        // Load, zero-wait
        apply_stimulus(16'h0040, 0, 5, 1, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 16'hBEEF); #3;
        check_output("ld0_req", dmem_req, 1);
        check_output("ld0_addr", dmem_addr, 16'h0040);
        check_output("ld0_we", dmem_we, 0);
        check_output("ld0_stall", mem_stall, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); #3;
        check_output("ld0_req_off", dmem_req, 0);
        check_output("ld0_writeVal", writeVal, 16'hBEEF);
        check_output("ld0_dest", dest, 5);
        check_output("ld0_writeEn", writeEn, 1);

        // Store, 3 waits, ALU op queued behind it
        apply_stimulus(16'h0010, 16'h00AA, 7, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(16'h5555, 0, 2, 1, 0, 0, 0, 0); #3;
            check_output("st_stall", mem_stall, 1);
            check_output("st_we", dmem_we, 1);
            check_output("st_wdata", dmem_wdata, 16'h00AA);
            check_output("st_wbenmem", WB_EN_MEM, 0);
            check_output("st_writeEn", writeEn, 0);
        end
        apply_stimulus(16'h5555, 0, 2, 1, 0, 0, 1, 0); #3;
        check_output("st_ack_stall", mem_stall, 0);
        check_output("st_ack_req", dmem_req, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); #3;
        check_output("st_done_writeEn", writeEn, 0);
        check_output("st_next_wbenmem", WB_EN_MEM, 1);
        check_output("st_next_destmem", dest_MEM, 2);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); #3;
        check_output("st_next_writeVal", writeVal, 16'h5555);
        check_output("st_next_writeEn", writeEn, 1);

        // Back-to-back load then store
        apply_stimulus(16'h0100, 0, 4, 1, 1, 0, 0, 0);
        apply_stimulus(16'h0200, 16'h3333, 1, 0, 0, 1, 0, 0); #3;
        check_output("b2b_ld_stall", mem_stall, 1);
        check_output("b2b_ld_addr", dmem_addr, 16'h0100);
        apply_stimulus(16'h0200, 16'h3333, 1, 0, 0, 1, 1, 16'h7777); #3;
        check_output("b2b_ld_ack_stall", mem_stall, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); #3;
        check_output("b2b_st_req", dmem_req, 1);
        check_output("b2b_st_addr", dmem_addr, 16'h0200);
        check_output("b2b_st_we", dmem_we, 1);
        check_output("b2b_ld_writeVal", writeVal, 16'h7777);
        check_output("b2b_ld_dest", dest, 4);
        check_output("b2b_ld_writeEn", writeEn, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0); #3;
        check_output("b2b_st_ack_stall", mem_stall, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); #3;
        check_output("b2b_idle_req", dmem_req, 0);
        check_output("b2b_st_writeEn", writeEn, 0);

        // Timeout on a load
        check_output("to_err_before", mem_err, 0);
        apply_stimulus(16'h0300, 0, 6, 1, 1, 0, 0, 0);
        req_cycles = 0;
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(16'h0ABC, 0, 9, 1, 0, 0, 0, 0); #3;
            if (dmem_req) req_cycles++;
        end
        check_output("to_req_cycles", req_cycles, TIMEOUT_CYC);
        check_output("to_err", mem_err, 1);
        check_output("to_next_writeVal", writeVal, 16'h0ABC);
        check_output("to_next_dest", dest, 9);
        check_output("to_next_writeEn", writeEn, 1);

        // Reset in the second ACCESS cycle
        apply_stimulus(16'h0400, 0, 8, 1, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); #3;
        check_output("rm_req_before", dmem_req, 1);
        rst = 1'b0; #1;
        check_output("rm_req", dmem_req, 0);
        check_output("rm_stall", mem_stall, 0);
        check_output("rm_writeEn", writeEn, 0);
        check_output("rm_err", mem_err, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 16'hDEAD);
        rst = 1'b1; #3;
        check_output("rm_late_ack_req", dmem_req, 0);
        check_output("rm_late_ack_stall", mem_stall, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); #3;
        check_output("rm_after_writeEn", writeEn, 0);
        check_output("rm_after_req", dmem_req, 0);
        apply_stimulus(16'h00C3, 0, 1, 1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0); #3;
        check_output("rm_alu_writeVal", writeVal, 16'h00C3);
        check_output("rm_alu_writeEn", writeEn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the G1 pipeline, directly downstream of EXECUTE.
- Contains the EXE/MEM pipeline register, a data-memory access FSM with req/ack handshake and timeout, and the MEM/WB pipeline register.
- Supplies dest_MEM, WB_EN_MEM and the MEM-stage result to the hazard and forwarding units.
- Drives writeVal, dest and writeEn to regFile.

Parameters:
DATA_W, 16, data word width (REG_FILE_SIZE)
ADDR_W, 16, data-memory address width
REG_ADDR_W, 4, register index width (REG_FILE_ADDR_LEN)
TIMEOUT_CYC, 15, maximum ACCESS cycles without ack before abort (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
alu_result_in  in  DATA_W  EXE result; memory address for loads and stores
st_value_in  in  DATA_W  forwarded store data (ST_reg_out)
dest_in  in  REG_ADDR_W  destination register
wb_en_in  in  1  writeback enable from EXE
mem_r_en_in  in  1  load
mem_w_en_in  in  1  store
mem_stall  out  1  freeze request to the IF, ID and EXE registers
dest_MEM  out  REG_ADDR_W  EXE/MEM destination, to hazard and forwarding units
WB_EN_MEM  out  1  EXE/MEM writeback enable
mem_result_fwd  out  DATA_W  EXE/MEM alu_result, to EXECUTE mem_result
dmem_req  out  1  access request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  EXE/MEM alu_result[ADDR_W-1:0]
dmem_wdata  out  DATA_W  EXE/MEM store value
dmem_rdata  in  DATA_W  read data, valid when dmem_ack=1
dmem_ack  in  1  access complete
writeVal  out  DATA_W  MEM/WB writeback value
dest  out  REG_ADDR_W  MEM/WB destination
writeEn  out  1  MEM/WB writeback enable
mem_err  out  1  sticky timeout flag

Behaviour:
Reset (rst=0, asynchronous):
- All registers clear to 0 immediately and the FSM enters IDLE.
- dmem_req drops in the same instant.
- Every output is 0.
- A reset during ACCESS abandons the access; no writeback occurs.

EXE/MEM register:
- Captures all *_in signals on each rising edge where mem_stall=0.
- Holds its contents while mem_stall=1.
- mem_op = mem_r_en | mem_w_en of the registered values.
- If both enables are set, the op is a store (write priority) and WB_EN is forced to 0 for that instruction.

FSM, IDLE to ACCESS:
- IDLE: on any edge capturing an instruction with mem_op=1, go to ACCESS and clear timeout_cnt to 0.

FSM, in ACCESS:
- dmem_req=1 and dmem_we=registered mem_w_en.
- dmem_addr and dmem_wdata are driven from EXE/MEM and stay stable until the access ends.
- mem_stall = (state==ACCESS) & ~dmem_ack. This is combinational, so an ack in the first ACCESS cycle gives a one-cycle access.

FSM, ack received:
- On an edge with dmem_ack=1, go to IDLE unless the newly captured instruction is a mem op, in which case re-enter ACCESS with the counter cleared.
- The MEM/WB register takes the load result (dmem_rdata) or the store (writeEn=0).

FSM, timeout:
- In ACCESS, timeout_cnt increments each cycle without ack.
- On the edge where timeout_cnt==TIMEOUT_CYC-1 and dmem_ack=0: abort.
  - Go to IDLE and set mem_err=1; it clears only on reset.
  - MEM/WB writeEn=0.
  - mem_stall deasserts combinationally during that last cycle so the pipeline advances.

dmem_ack outside ACCESS is ignored. dmem_req is never asserted in IDLE.

MEM/WB register, updated every edge:
- mem_stall=1: insert a bubble (writeEn=0, writeVal and dest hold their previous values).
- Otherwise, non-memory op: writeVal=alu_result, dest=dest_EXE/MEM, writeEn=wb_en.
- Otherwise, load: writeVal=dmem_rdata, writeEn=wb_en, or 0 if the load aborted.
- Otherwise, store: writeEn=0.

Forwarding outputs:
- dest_MEM, WB_EN_MEM and mem_result_fwd are direct EXE/MEM register outputs.
- WB_EN_MEM is 0 for a store and for an empty slot.

Latency:
- Non-memory op: EXE to WB in 1 cycle.
- Memory op: 1 cycle plus one for each cycle without ack.

Test Plan:
- ALU passthrough: alu_result_in=0x1234, dest_in=3, wb_en_in=1, no mem op -> next cycle WB_EN_MEM=1, dest_MEM=3; one cycle later writeVal=0x1234, dest=3, writeEn=1; mem_stall stays 0.
- Load, zero-wait: mem_r_en_in=1, alu_result_in=0x0040, dest_in=5; ack with rdata=0xBEEF in the first ACCESS cycle -> dmem_req=1, dmem_addr=0x0040, dmem_we=0 for exactly 1 cycle, mem_stall=0; next cycle writeVal=0xBEEF, dest=5, writeEn=1.
- Store, 3-wait: mem_w_en_in=1, alu_result_in=0x0010, st_value_in=0x00AA; ack after 3 cycles -> mem_stall=1 for 3 cycles with EXE/MEM held; dmem_we=1, dmem_wdata=0x00AA stable; writeEn=0 throughout; the following ALU op then completes normally.
- Back-to-back: load then store, each acked after 1 wait -> two separate ACCESS episodes; dmem_req drops for no cycle in between (re-enter path); addresses appear in order.
- Timeout: load with ack held at 0, TIMEOUT_CYC=15 -> dmem_req high exactly 15 cycles, then mem_err=1 (sticky); writeEn=0 for that load; the next instruction proceeds.
- Reset mid-access: rst pulled low in the 2nd ACCESS cycle -> dmem_req, mem_stall, writeEn and mem_err go to 0 without waiting for a clock; after release the FSM is in IDLE and a late dmem_ack=1 has no effect.
